// File: rtl/accum_ctrl.sv
// -----------------------------------------------------------------------------
// accum_ctrl
//
// Accumulates a sequence of unsigned operand beats and presents the sum, a
// sticky carry flag and a beat count once the last beat has been taken.
//
// Sequence: IDLE --start--> ACCUM --(accepted beat with in_last)--> DONE
//           --out_ready--> IDLE.
// start is honoured only in IDLE. in_ready and out_valid decode the state.
// out_sum, out_carry and out_count come straight from registers and keep
// their values in IDLE until the next start clears them.
//
// Configuration macro:
//   ACCUM_SATURATE_EN  defined   -> a beat whose addition carries out leaves
//                                   the accumulator at all ones.
//                      undefined -> the accumulator wraps modulo 2^WIDTH.
//   In both builds out_carry records the carry.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2)
//   CNT_W  beat-counter width in bits (the count saturates at all ones)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a new accumulation (IDLE only)
//   in_valid   operand beat valid
//   in_data    unsigned operand
//   in_last    final operand of the sequence, qualified by in_valid
//   in_ready   block accepts an operand this cycle (ACCUM)
//   out_valid  result available (DONE)
//   out_ready  downstream takes the result
//   out_sum    accumulated sum
//   out_carry  sticky carry-out of any beat
//   out_count  number of beats accepted
// -----------------------------------------------------------------------------
module accum_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

`ifdef ACCUM_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Ripple-style WIDTH-bit add with the carry-out kept as an extra top bit.
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    assign add_full  = {1'b0, acc_q} + {1'b0, in_data};
    assign add_sum   = add_full[WIDTH-1:0];
    assign add_carry = add_full[WIDTH];

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                end
            end

            S_ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone qualifies
                // a beat; in_last without in_valid has no effect.
                if (in_valid) begin
                    acc_d   = (SAT_EN && add_carry) ? '1 : add_sum;
                    carry_d = carry_q | add_carry;
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // computed from the same pre-edge state.
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accum_ctrl
//
// Self-checking bench for accum_ctrl (WIDTH=4, CNT_W=8). Each sequence's
// expected result is computed from the list of beats with plain integer
// arithmetic. Define ACCUM_SATURATE_EN for both bench and RTL to check the
// saturating build.
// -----------------------------------------------------------------------------
module tb_accum_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int MAX_V = (1 << WIDTH) - 1;
    localparam int MAX_C = (1 << CNT_W) - 1;

`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int beats[$];
    int exp_sum;
    int exp_carry;
    int exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result of the beats list.
    task automatic model();
        int s;
        int c;
        s = 0;
        c = 0;
        foreach (beats[i]) begin
            s = s + beats[i];
            if (s > MAX_V) begin
                c = 1;
                s = SAT ? MAX_V : s - (MAX_V + 1);
            end
        end
        exp_sum   = s;
        exp_carry = c;
        exp_count = (beats.size() > MAX_C) ? MAX_C : beats.size();
    endtask

    task automatic check_outputs(input string tag, input bit ready, input bit valid,
                                 input int sum, input int carry, input int count);
        check({tag, ".in_ready"},  32'(in_ready),  32'(ready));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(valid));
        check({tag, ".out_sum"},   32'(out_sum),   sum);
        check({tag, ".out_carry"}, 32'(out_carry), carry);
        check({tag, ".out_count"}, 32'(out_count), count);
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    // Full sequence: start, beats (with up to max_gap idle cycles before each,
    // carrying random in_last/start noise), hold cycles in DONE with stray
    // start, then acceptance with a coinciding start that must be ignored.
    task automatic run_seq(input string tag, input int max_gap, input int hold);
        int gap;
        int n;
        n = beats.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outputs({tag, ".start"}, 1'b1, 1'b0, 0, 0, 0);

        foreach (beats[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(1, 0));
                in_data  = WIDTH'($urandom_range(MAX_V, 0));
                start    = 1'($urandom_range(1, 0));
                tick();
                check({tag, ".gap.in_ready"},  32'(in_ready),  32'd1);
                check({tag, ".gap.out_count"}, 32'(out_count), (i > MAX_C) ? MAX_C : i);
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(beats[i]);
            in_last  = (i == n - 1);
            start    = 1'($urandom_range(1, 0));
            tick();
        end
        idle_inputs();

        model();
        check_outputs({tag, ".done"}, 1'b0, 1'b1, exp_sum, exp_carry, exp_count);

        repeat (hold) begin
            start    = 1'($urandom_range(1, 0));
            in_valid = 1'($urandom_range(1, 0));
            in_last  = 1'b1;
            tick();
            check_outputs({tag, ".hold"}, 1'b0, 1'b1, exp_sum, exp_carry, exp_count);
        end

        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        idle_inputs();
        check_outputs({tag, ".idle"}, 1'b0, 1'b0, exp_sum, exp_carry, exp_count);
        tick();
        check_outputs({tag, ".idle2"}, 1'b0, 1'b0, exp_sum, exp_carry, exp_count);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_outputs("post_reset", 1'b0, 1'b0, 0, 0, 0);

        // Basic back-to-back beats.
        beats = '{3, 5, 2};
        run_seq("basic", 0, 1);

        // Overflow: wrap or saturate depending on build.
        beats = '{9, 9};
        run_seq("overflow", 0, 0);

        // Saturating build keeps all ones on further carries; wrapping build
        // keeps counting modulo 16.
        beats = '{15, 1, 0, 7};
        run_seq("overflow_multi", 1, 1);

        // Handshake: gaps between beats, 5 cycles of back-pressure.
        beats = '{1, 1, 1};
        run_seq("handshake", 1, 5);

        // Back-to-back sequence with no carry-over.
        beats = '{1};
        run_seq("b2b", 0, 0);

        // Reset mid-ACCUM, with in_valid and start also asserted.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd7;
        tick();
        in_data = 4'd4;
        tick();
        rst       = 1'b1;
        in_data   = 4'd5;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check_outputs("rst_accum", 1'b0, 1'b0, 0, 0, 0);
        tick();
        check_outputs("rst_accum2", 1'b0, 1'b0, 0, 0, 0);

        // Reset mid-DONE.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd5;
        in_last  = 1'b1;
        tick();
        idle_inputs();
        check("rst_done.pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs("rst_done", 1'b0, 1'b0, 0, 0, 0);

        // Count saturation: 300 zero beats.
        beats.delete();
        repeat (300) beats.push_back(0);
        run_seq("count_sat", 0, 0);

        // Random sequences.
        for (int k = 0; k < 20; k++) begin
            int len;
            len = int'($urandom_range(8, 1));
            beats.delete();
            repeat (len) beats.push_back(int'($urandom_range(MAX_V, 0)));
            run_seq("random", 2, int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
